mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 168 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply or restoring divide,
// one iteration per clock, 64-bit result into HI/LO.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] Data_A,
  input  logic [31:0] Data_B,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned W     = 32;
  localparam int unsigned AW    = W + 1;
  localparam int unsigned CW    = 6;
  localparam int unsigned ITERS = 32;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  // acc_q is the Booth accumulator or the divide partial remainder; q_q is the
  // Booth multiplier or the dividend/quotient shift register.
  logic [AW-1:0]   acc_q;
  logic [W-1:0]    q_q;
  logic            qm1_q;
  logic [W-1:0]    opnd_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic            busy_q;
  logic            done_q;
  logic            dz_q;

  logic [AW-1:0]   mcand_x;
  logic [AW-1:0]   booth_sum;
  logic [AW-1:0]   booth_acc_d;
  logic [W-1:0]    booth_q_d;
  logic            booth_qm1_d;
  logic [AW-1:0]   div_shift;
  logic [AW-1:0]   div_trial;
  logic [AW-1:0]   div_rem_d;
  logic [W-1:0]    div_quo_d;
  logic [W-1:0]    quo_res;
  logic [W-1:0]    rem_res;
  logic [W-1:0]    abs_a;
  logic [W-1:0]    abs_b;

  // One Booth step: add/subtract multiplicand, then arithmetic shift of {acc, Q, q-1}.
  always_comb begin
    mcand_x   = {opnd_q[W-1], opnd_q};
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_x;
      2'b10:   booth_sum = acc_q - mcand_x;
      default: booth_sum = acc_q;
    endcase
    {booth_acc_d, booth_q_d, booth_qm1_d} = {booth_sum[AW-1], booth_sum, q_q};
  end

  // One restoring-divide step on magnitudes plus final sign fix-up.
  always_comb begin
    div_shift = {acc_q[W-1:0], q_q[W-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (div_trial[AW-1]) begin
      div_rem_d = div_shift;
      div_quo_d = {q_q[W-2:0], 1'b0};
    end else begin
      div_rem_d = div_trial;
      div_quo_d = {q_q[W-2:0], 1'b1};
    end
    quo_res = neg_quo_q ? W'(-div_quo_d) : div_quo_d;
    rem_res = neg_rem_q ? W'(-div_rem_d[W-1:0]) : div_rem_d[W-1:0];
    abs_a   = Data_A[W-1] ? W'(-Data_A) : Data_A;
    abs_b   = Data_B[W-1] ? W'(-Data_B) : Data_B;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_mult) begin
            opnd_q  <= Data_A;
            q_q     <= Data_B;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= CW'(ITERS);
            busy_q  <= 1'b1;
            dz_q    <= 1'b0;
            state_q <= MULT;
          end else if (start_div) begin
            if (Data_B == '0) begin
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              opnd_q    <= abs_b;
              q_q       <= abs_a;
              acc_q     <= '0;
              neg_quo_q <= Data_A[W-1] ^ Data_B[W-1];
              neg_rem_q <= Data_A[W-1];
              cnt_q     <= CW'(ITERS);
              busy_q    <= 1'b1;
              dz_q      <= 1'b0;
              state_q   <= DIV;
            end
          end
        end
        MULT: begin
          acc_q <= booth_acc_d;
          q_q   <= booth_q_d;
          qm1_q <= booth_qm1_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= booth_acc_d[W-1:0];
            lo_q    <= booth_q_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DIV: begin
          acc_q <= div_rem_d;
          q_q   <= div_quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= rem_res;
            lo_q    <= quo_res;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] Data_A;
  logic [31:0] Data_B;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int failures = 0;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start_mult(start_mult),
    .start_div (start_div),
    .Data_A    (Data_A),
    .Data_B    (Data_B),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Issue one start, scramble operands after acceptance, wait for done (bounded).
  task automatic run_op(input logic sm, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, output int cyc, output int busy_cnt);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    Data_A     = a;
    Data_B     = b;
    @(posedge clk); #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    Data_A     = 32'hDEADBEEF;
    Data_B     = 32'h0;
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic finish_op(input string name);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_len: done=%b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_mult = 0; start_div = 0; Data_A = 0; Data_B = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hi_out, lo_out, busy, done, div_zero} !== 67'h0) begin
      failures++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b expected all 0",
               hi_out, lo_out, busy, done, div_zero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult_neg();
    int cyc, bc;
    run_op(1, 0, 32'd7, 32'hFFFFFFFD, cyc, bc);
    checks++;
    if (cyc !== 32) begin failures++; $display("FAIL mult_latency: got %0d expected 32", cyc); end
    checks++;
    if (bc !== 32) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected 32", bc); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
    checks++;
    if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_hi: got %h expected FFFFFFFF", hi_out); end
    checks++;
    if (lo_out !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_lo: got %h expected FFFFFFEB", lo_out); end
    finish_op("mult_neg");
  endtask

  task automatic test_mult_minmin();
    int cyc, bc;
    run_op(1, 0, 32'h80000000, 32'h80000000, cyc, bc);
    checks++;
    if (cyc !== 32) begin failures++; $display("FAIL minmin_latency: got %0d expected 32", cyc); end
    checks++;
    if (hi_out !== 32'h40000000) begin failures++; $display("FAIL minmin_hi: got %h expected 40000000", hi_out); end
    checks++;
    if (lo_out !== 32'h0) begin failures++; $display("FAIL minmin_lo: got %h expected 00000000", lo_out); end
    finish_op("minmin");
  endtask

  task automatic test_div_signs();
    int cyc, bc;
    run_op(0, 1, 32'hFFFFFFF9, 32'd2, cyc, bc);
    checks++;
    if (cyc !== 32 || bc !== 32) begin
      failures++; $display("FAIL div_latency: cyc=%0d busy=%0d expected 32/32", cyc, bc);
    end
    checks++;
    if (lo_out !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negA_lo: got %h expected FFFFFFFD", lo_out); end
    checks++;
    if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_negA_hi: got %h expected FFFFFFFF", hi_out); end
    finish_op("div_negA");
    run_op(0, 1, 32'd7, 32'hFFFFFFFE, cyc, bc);
    checks++;
    if (lo_out !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negB_lo: got %h expected FFFFFFFD", lo_out); end
    checks++;
    if (hi_out !== 32'h00000001) begin failures++; $display("FAIL div_negB_hi: got %h expected 00000001", hi_out); end
    finish_op("div_negB");
  endtask

  task automatic test_div_overflow();
    int cyc, bc;
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, cyc, bc);
    checks++;
    if (lo_out !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo_out); end
    checks++;
    if (hi_out !== 32'h0) begin failures++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi_out); end
    finish_op("div_ovf");
  endtask

  task automatic test_div_zero();
    int cyc, bc;
    run_op(1, 0, 32'd6, 32'h2AAAAAAB, cyc, bc);
    checks++;
    if (hi_out !== 32'd1 || lo_out !== 32'd2) begin
      failures++; $display("FAIL dz_setup: hi=%h lo=%h expected 1/2", hi_out, lo_out);
    end
    finish_op("dz_setup");
    run_op(0, 1, 32'd5, 32'd0, cyc, bc);
    checks++;
    if (cyc !== 0) begin failures++; $display("FAIL dz_latency: got %0d expected 0", cyc); end
    checks++;
    if (busy !== 1'b0 || bc !== 0) begin
      failures++; $display("FAIL dz_busy: busy=%b busy_cycles=%0d expected 0/0", busy, bc);
    end
    checks++;
    if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
    checks++;
    if (hi_out !== 32'd1 || lo_out !== 32'd2) begin
      failures++; $display("FAIL dz_hold: hi=%h lo=%h expected 1/2", hi_out, lo_out);
    end
    finish_op("dz");
    checks++;
    if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_sticky: got %b expected 1", div_zero); end
    // Both starts with B=0: multiply must win, so no divide-by-zero.
    run_op(1, 1, 32'hFFFFFFFF, 32'd0, cyc, bc);
    checks++;
    if (cyc !== 32 || div_zero !== 1'b0) begin
      failures++; $display("FAIL both_start: cyc=%0d dz=%b expected 32/0", cyc, div_zero);
    end
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
      failures++; $display("FAIL both_start_result: hi=%h lo=%h expected 0/0", hi_out, lo_out);
    end
    finish_op("both_start");
    run_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bc);
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h1) begin
      failures++; $display("FAIL negneg: hi=%h lo=%h expected 0/1", hi_out, lo_out);
    end
    finish_op("negneg");
  endtask

  task automatic test_reset_midop();
    int cyc, bc;
    @(negedge clk);
    start_mult = 1'b1; Data_A = 32'h00012345; Data_B = 32'h00000100;
    @(posedge clk); #1;
    start_mult = 1'b0; Data_A = 32'h0; Data_B = 32'h5;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL ignore_start: busy=%b done=%b expected 1/0", busy, done);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({hi_out, lo_out, busy, done, div_zero} !== 67'h0) begin
      failures++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b dz=%b expected all 0",
               hi_out, lo_out, busy, done, div_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(1, 0, 32'd3, 32'd4, cyc, bc);
    checks++;
    if (cyc !== 32) begin failures++; $display("FAIL post_reset_latency: got %0d expected 32", cyc); end
    checks++;
    if (lo_out !== 32'd12 || hi_out !== 32'd0) begin
      failures++; $display("FAIL post_reset_result: hi=%h lo=%h expected 0/C", hi_out, lo_out);
    end
    finish_op("post_reset");
  endtask

  initial begin
    test_reset();
    test_mult_neg();
    test_mult_minmin();
    test_div_signs();
    test_div_overflow();
    test_div_zero();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
